// File: rtl/bp_lce_req_stream_buffer_if.sv
// rtl/bp_lce_req_stream_buffer_if.sv - request-in / header-and-beat-out bundle for the LCE request stream buffer
interface bp_lce_req_stream_buffer_if
  #(parameter int header_width_p = 128
   ,parameter int data_width_p   = 512
   ,parameter int beat_width_p   = 64
   ,parameter int lg_beats_lp    = $clog2(data_width_p / beat_width_p + 1)
   );

  logic [header_width_p-1:0] lce_req_header_i;
  logic [data_width_p-1:0]   lce_req_data_i;
  logic [lg_beats_lp-1:0]    lce_req_beats_i;
  logic                      lce_req_v_i;
  logic                      lce_req_ready_then_o;

  logic [header_width_p-1:0] header_o;
  logic                      header_v_o;
  logic                      header_yumi_i;

  logic [beat_width_p-1:0]   data_o;
  logic                      data_v_o;
  logic                      data_last_o;
  logic                      data_yumi_i;

  // master: request producer and stream consumer; slave: the buffer itself
  modport master
    (output lce_req_header_i, lce_req_data_i, lce_req_beats_i, lce_req_v_i
    ,input  lce_req_ready_then_o
    ,input  header_o, header_v_o
    ,output header_yumi_i
    ,input  data_o, data_v_o, data_last_o
    ,output data_yumi_i
    );

  modport slave
    (input  lce_req_header_i, lce_req_data_i, lce_req_beats_i, lce_req_v_i
    ,output lce_req_ready_then_o
    ,output header_o, header_v_o
    ,input  header_yumi_i
    ,output data_o, data_v_o, data_last_o
    ,input  data_yumi_i
    );

endinterface

// File: rtl/bp_lce_req_stream_buffer.sv
// rtl/bp_lce_req_stream_buffer.sv - whole-message LCE request buffer emitting a header then link-width data beats
module bp_lce_req_stream_buffer
  #(parameter int header_width_p = 128
   ,parameter int data_width_p   = 512
   ,parameter int beat_width_p   = 64
   ,parameter int els_p          = 2
   ,localparam int beats_lp      = data_width_p / beat_width_p
   ,localparam int lg_beats_lp   = $clog2(beats_lp + 1)
   )
  (input logic clk_i
  ,input logic reset_i
  ,bp_lce_req_stream_buffer_if.slave lce_req_if
  );

  localparam int lg_cnt_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int lg_occ_lp = $clog2(els_p + 1);

  typedef enum logic {e_header, e_data} state_e;
  state_e state_r, state_n;

  logic [header_width_p-1:0]               header_mem [els_p];
  logic [beats_lp-1:0][beat_width_p-1:0]   data_mem   [els_p];
  logic [lg_beats_lp-1:0]                  beats_mem  [els_p];

  logic [lg_els_lp-1:0] wptr_r, rptr_r;
  logic [lg_occ_lp-1:0] occ_r;
  logic [lg_cnt_lp-1:0] beat_cnt_r, beat_cnt_n;
  logic [lg_beats_lp-1:0] head_beats;
  logic enq, deq, empty, full, last_beat;
  logic header_v, data_v, data_last;

  assign empty      = (occ_r == '0);
  assign full       = (occ_r == lg_occ_lp'(els_p));
  assign enq        = lce_req_if.lce_req_v_i & ~full;
  assign head_beats = beats_mem[rptr_r];
  assign last_beat  = (lg_beats_lp'(beat_cnt_r) == head_beats - lg_beats_lp'(1));

  assign lce_req_if.lce_req_ready_then_o = ~full;
  assign lce_req_if.header_o    = header_mem[rptr_r];
  assign lce_req_if.header_v_o  = header_v;
  assign lce_req_if.data_o      = data_mem[rptr_r][beat_cnt_r];
  assign lce_req_if.data_v_o    = data_v;
  assign lce_req_if.data_last_o = data_last;

  always_comb begin
    state_n    = state_r;
    beat_cnt_n = beat_cnt_r;
    deq        = 1'b0;
    header_v   = 1'b0;
    data_v     = 1'b0;
    data_last  = 1'b0;
    unique case (state_r)
      e_header: begin
        header_v = ~empty;
        if (lce_req_if.header_yumi_i & ~empty) begin
          if (head_beats == '0) begin
            deq = 1'b1;
          end else begin
            state_n    = e_data;
            beat_cnt_n = '0;
          end
        end
      end
      e_data: begin
        data_v    = 1'b1;
        data_last = last_beat;
        if (lce_req_if.data_yumi_i) begin
          if (last_beat) begin
            deq        = 1'b1;
            beat_cnt_n = '0;
            state_n    = e_header;
          end else begin
            beat_cnt_n = beat_cnt_r + lg_cnt_lp'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_header;
      beat_cnt_r <= '0;
      wptr_r     <= '0;
      rptr_r     <= '0;
      occ_r      <= '0;
    end else begin
      state_r    <= state_n;
      beat_cnt_r <= beat_cnt_n;
      if (enq)
        wptr_r <= (wptr_r == lg_els_lp'(els_p - 1)) ? '0 : wptr_r + lg_els_lp'(1);
      if (deq)
        rptr_r <= (rptr_r == lg_els_lp'(els_p - 1)) ? '0 : rptr_r + lg_els_lp'(1);
      if (enq & ~deq)
        occ_r <= occ_r + lg_occ_lp'(1);
      else if (~enq & deq)
        occ_r <= occ_r - lg_occ_lp'(1);
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      header_mem[wptr_r] <= lce_req_if.lce_req_header_i;
      data_mem[wptr_r]   <= lce_req_if.lce_req_data_i;
      beats_mem[wptr_r]  <= lce_req_if.lce_req_beats_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(lce_req_if.lce_req_v_i && full));
      assert (!lce_req_if.lce_req_v_i || (lce_req_if.lce_req_beats_i <= lg_beats_lp'(beats_lp)));
      assert (!lce_req_if.header_yumi_i || header_v);
      assert (!lce_req_if.data_yumi_i || data_v);
    end
  end

endmodule

// File: tb/tb_bp_lce_req_stream_buffer.sv
// tb/tb_bp_lce_req_stream_buffer.sv - scoreboard bench for bp_lce_req_stream_buffer
module tb_bp_lce_req_stream_buffer;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  bp_lce_req_stream_buffer_if bus();

  bp_lce_req_stream_buffer dut
    (.clk_i     (clk_i)
    ,.reset_i   (reset_i)
    ,.lce_req_if(bus)
    );

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] exp_hdr  [$];
  logic [64:0]  exp_beat [$];
  int yumi_pct   = 0;
  bit manual_hdr = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic enq(input logic [127:0] h, input logic [511:0] d, input int beats);
    int g = 0;
    bit idle;
    while (!bus.lce_req_ready_then_o && g < 200) begin
      step();
      g++;
    end
    if (!bus.lce_req_ready_then_o) begin
      check("enq_ready_timeout", 128'(bus.lce_req_ready_then_o), 128'd1);
      return;
    end
    idle = (exp_hdr.size() == 0) && (exp_beat.size() == 0) && !bus.header_v_o && !bus.data_v_o;
    bus.lce_req_header_i = h;
    bus.lce_req_data_i   = d;
    bus.lce_req_beats_i  = beats[3:0];
    bus.lce_req_v_i      = 1'b1;
    if (idle) begin
      #1;
      check("no_bypass", 128'(bus.header_v_o), 128'd0);
    end
    exp_hdr.push_back(h);
    for (int k = 0; k < beats; k++)
      exp_beat.push_back({(k == beats - 1), d[k*64 +: 64]});
    step();
    bus.lce_req_v_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_hdr.size() != 0 || exp_beat.size() != 0 || bus.header_v_o || bus.data_v_o) && g < 500) begin
      step();
      g++;
    end
    check("drained", 128'(exp_hdr.size() + exp_beat.size()), 128'd0);
    check("idle_ready", 128'(bus.lce_req_ready_then_o), 128'd1);
  endtask

  // Consumer: samples at negedge, raises yumi for the following posedge.
  initial begin
    logic [127:0] h;
    logic [64:0]  b;
    bus.header_yumi_i = 1'b0;
    bus.data_yumi_i   = 1'b0;
    forever begin
      @(negedge clk_i);
      bus.header_yumi_i = 1'b0;
      bus.data_yumi_i   = 1'b0;
      if (!reset_i) begin
        if (bus.header_v_o || bus.data_v_o)
          check("valid_excl", 128'(bus.header_v_o & bus.data_v_o), 128'd0);
        if (bus.header_v_o && (manual_hdr || $urandom_range(99) < yumi_pct)) begin
          if (exp_hdr.size() == 0) begin
            check("hdr_unexpected", 128'(bus.header_v_o), 128'd0);
          end else begin
            h = exp_hdr.pop_front();
            check("hdr", bus.header_o, h);
            bus.header_yumi_i = 1'b1;
          end
        end
        if (bus.data_v_o && ($urandom_range(99) < yumi_pct)) begin
          if (exp_beat.size() == 0) begin
            check("beat_unexpected", 128'(bus.data_v_o), 128'd0);
          end else begin
            b = exp_beat.pop_front();
            check("beat", 128'({bus.data_last_o, bus.data_o}), 128'(b));
            bus.data_yumi_i = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] d;
    int mix [5] = '{0, 3, 0, 8, 1};
    int g;

    reset_i              = 1'b1;
    bus.lce_req_v_i      = 1'b0;
    bus.lce_req_header_i = '0;
    bus.lce_req_data_i   = '0;
    bus.lce_req_beats_i  = '0;
    repeat (3) step();
    check("rst_ready", 128'(bus.lce_req_ready_then_o), 128'd1);
    check("rst_hv",    128'(bus.header_v_o), 128'd0);
    check("rst_dv",    128'(bus.data_v_o), 128'd0);
    check("rst_dlast", 128'(bus.data_last_o), 128'd0);
    reset_i = 1'b0;
    step();
    check("post_rst_ready", 128'(bus.lce_req_ready_then_o), 128'd1);
    check("post_rst_hv",    128'(bus.header_v_o), 128'd0);

    // header-only message
    yumi_pct = 0;
    enq(128'h11, '0, 0);
    check("t1_hv",  128'(bus.header_v_o), 128'd1);
    check("t1_hdr", bus.header_o, 128'h11);
    yumi_pct = 100;
    drain();

    // single beat
    d = '0;
    d[63:0] = 64'hDEADBEEF_CAFEF00D;
    enq(128'h12, d, 1);
    drain();

    // eight beats, beat k = k, random consumer
    d = '0;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'(k);
    yumi_pct = 50;
    enq(128'h13, d, 8);
    drain();

    // fill with the consumer stalled
    yumi_pct = 0;
    enq(128'h21, '0, 0);
    enq(128'h22, '0, 0);
    check("full_ready", 128'(bus.lce_req_ready_then_o), 128'd0);
    manual_hdr = 1'b1;
    step();
    check("ready_after_pop", 128'(bus.lce_req_ready_then_o), 128'd1);
    enq(128'h23, '0, 0);
    manual_hdr = 1'b0;
    check("simul_ready", 128'(bus.lce_req_ready_then_o), 128'd1);
    check("simul_hv",    128'(bus.header_v_o), 128'd1);
    check("simul_hdr",   bus.header_o, 128'h23);
    enq(128'h24, '0, 0);
    check("refull_ready", 128'(bus.lce_req_ready_then_o), 128'd0);
    yumi_pct = 100;
    drain();

    // mixed messages through the two-entry ring
    yumi_pct = 50;
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      enq(128'(32'h50 + i), d, mix[i]);
    end
    drain();

    // reset during beat 4 of an 8-beat message with another queued
    yumi_pct = 100;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'(k);
    enq(128'h81, d, 8);
    enq(128'h82, '0, 0);
    g = 0;
    while (!(bus.data_v_o && bus.data_o == 64'd4) && g < 100) begin
      step();
      g++;
    end
    check("beat4_reached", 128'(bus.data_o), 128'd4);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    exp_hdr.delete();
    exp_beat.delete();
    check("midrst_hv",    128'(bus.header_v_o), 128'd0);
    check("midrst_dv",    128'(bus.data_v_o), 128'd0);
    check("midrst_ready", 128'(bus.lce_req_ready_then_o), 128'd1);
    check("midrst_dlast", 128'(bus.data_last_o), 128'd0);
    repeat (20) step();
    check("quiet_hv", 128'(bus.header_v_o), 128'd0);
    check("quiet_dv", 128'(bus.data_v_o), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
